vis_marker_ctrl: RTL

Frame-synchronous controller for the circle-marker overlay stage of the vision pipeline. Up to four centroid producers (e.g. per-colour trackers) post marker coordinates through a valid/ready mailbox. On each frame start the block picks one pending coordinate by round-robin and presents it to the overlay as a stable `mark_x`/`mark_y`. It blanks the marker when no fresh coordinate has arrived for a configurable number of frames.

---
 rtl/vis_marker_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vis_marker_ctrl.sv
// vis_marker_ctrl: frame-synchronous marker selector for the circle overlay.
// Four producers post coordinates into one-deep mailboxes. On each frame
// start a short round-robin scan picks one pending, enabled mailbox and
// latches it onto the overlay outputs. If no fresh coordinate arrives for
// STALE_FRAMES frame starts, the marker is blanked.
//
// Handshake (every source i): a transfer happens at a rising clk edge when
// src_valid[i] & src_ready[i] are both 1. src_ready[i] is 1 exactly when
// mailbox i is empty. It depends only on the mailbox flag, never on
// src_valid. A producer holds its data stable while valid is high and not
// yet accepted. An out-of-range transfer is still accepted, but its data is
// dropped.
module vis_marker_ctrl #(
    parameter int IMG_W        = 1280,
    parameter int IMG_H        = 720,
    parameter int STALE_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic [3:0]  src_valid,
    input  logic [43:0] src_x,
    input  logic [43:0] src_y,
    output logic [3:0]  src_ready,
    input  logic [3:0]  src_mask,
    output logic [10:0] mark_x,
    output logic [10:0] mark_y,
    output logic        mark_en,
    output logic [1:0]  mark_src,
    output logic        coord_err,
    output logic        dbg_scan_o
);

    localparam logic [11:0] IMG_W_L = 12'(IMG_W);
    localparam logic [11:0] IMG_H_L = 12'(IMG_H);
    localparam logic [7:0]  STALE_L = 8'(STALE_FRAMES);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       scan_cnt_q, scan_cnt_d;
    logic [1:0]       rr_q, rr_d;
    logic [7:0]       age_q, age_d;
    logic [10:0]      mark_x_q, mark_x_d;
    logic [10:0]      mark_y_q, mark_y_d;
    logic             mark_en_q, mark_en_d;
    logic [1:0]       mark_src_q, mark_src_d;
    logic             vsync_q;
    logic [3:0]       pend_q;
    logic [3:0][10:0] mb_x_q;
    logic [3:0][10:0] mb_y_q;
    logic             coord_err_q;
    logic [3:0]       in_range;
    logic [1:0]       cand;
    logic             fs;
    logic             commit;

    assign fs         = vsync & ~vsync_q;
    assign cand       = rr_q + scan_cnt_q;
    assign src_ready  = ~pend_q;
    assign mark_x     = mark_x_q;
    assign mark_y     = mark_y_q;
    assign mark_en    = mark_en_q;
    assign mark_src   = mark_src_q;
    assign coord_err  = coord_err_q;
    assign dbg_scan_o = (state_q == ST_SCAN);

    // Per-source bounds check on the offered coordinate.
    always_comb begin
        in_range = '0;
        for (int i = 0; i < 4; i++) begin
            in_range[i] = ({1'b0, src_x[11*i +: 11]} < IMG_W_L) &&
                          ({1'b0, src_y[11*i +: 11]} < IMG_H_L);
        end
    end

    // Mailboxes: capture accepted in-range data, clear on commit, flag bad data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            mb_x_q      <= '0;
            mb_y_q      <= '0;
            coord_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (src_valid[i] && !pend_q[i]) begin
                    if (in_range[i]) begin
                        pend_q[i] <= 1'b1;
                        mb_x_q[i] <= src_x[11*i +: 11];
                        mb_y_q[i] <= src_y[11*i +: 11];
                    end else begin
                        coord_err_q <= 1'b1;
                    end
                end else if (commit && (cand == 2'(i))) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // Scan FSM next state plus marker, pointer and age updates.
    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q;
        rr_d       = rr_q;
        age_d      = age_q;
        mark_x_d   = mark_x_q;
        mark_y_d   = mark_y_q;
        mark_en_d  = mark_en_q;
        mark_src_d = mark_src_q;
        commit     = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (fs) begin
                    state_d    = ST_SCAN;
                    scan_cnt_d = 2'd0;
                end
            end
            ST_SCAN: begin
                if (pend_q[cand] && src_mask[cand]) begin
                    commit     = 1'b1;
                    mark_x_d   = mb_x_q[cand];
                    mark_y_d   = mb_y_q[cand];
                    mark_src_d = cand;
                    mark_en_d  = 1'b1;
                    rr_d       = cand + 2'd1;
                    age_d      = 8'd0;
                    state_d    = ST_WAIT;
                end else if (scan_cnt_q == 2'd3) begin
                    // A vsync edge seen while scanning is deliberately ignored.
                    age_d = (age_q == 8'hFF) ? age_q : age_q + 8'd1;
                    if (age_d >= STALE_L) begin
                        mark_en_d = 1'b0;
                    end
                    state_d = ST_WAIT;
                end else begin
                    scan_cnt_d = scan_cnt_q + 2'd1;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // State, marker registers and vsync edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WAIT;
            scan_cnt_q <= 2'd0;
            rr_q       <= 2'd0;
            age_q      <= 8'd0;
            mark_x_q   <= 11'd0;
            mark_y_q   <= 11'd0;
            mark_en_q  <= 1'b0;
            mark_src_q <= 2'd0;
            vsync_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            rr_q       <= rr_d;
            age_q      <= age_d;
            mark_x_q   <= mark_x_d;
            mark_y_q   <= mark_y_d;
            mark_en_q  <= mark_en_d;
            mark_src_q <= mark_src_d;
            vsync_q    <= vsync;
        end
    end

endmodule
